// File: rtl/prio_encoder_hs_pkg.sv
// Shared definitions for the prio_encoder_hs block.
//   - priority mode constants selected by the MODE parameter
//   - FSM state encoding for the output handshake
//   - index-width helper (ceil(log2(n)), never below 1)
package prio_encoder_hs_pkg;

    localparam int PRIO_LOW  = 0;   // lowest set index wins
    localparam int PRIO_HIGH = 1;   // highest set index wins
    localparam int PRIO_RR   = 2;   // round-robin after last grant

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // Width needed to hold indices 0..n-1; a 1-bit index is the floor.
    function automatic int clog2_min1(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << w) < 64'(n)) begin
                w = w + 1;
            end else begin
                w = w;
            end
        end
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/prio_encoder_hs_pick.sv
// prio_pick: combinational first-set finder.
//   vec    in  N  candidate vector
//   found  out 1  at least one bit of vec is set
//   idx    out W  index of the winning bit (0 when nothing is set)
//   onehot out N  one-hot form of idx, all zeros when nothing is set
// DIR = 0 picks the lowest set bit, DIR = 1 the highest.
module prio_pick
    import prio_encoder_hs_pkg::*;
#(
    parameter int N   = 16,
    parameter int DIR = 0,
    parameter int W   = 4
) (
    input  logic [N-1:0] vec,
    output logic         found,
    output logic [W-1:0] idx,
    output logic [N-1:0] onehot
);

    localparam logic [N-1:0] ONE_N = {{(N-1){1'b0}}, 1'b1};

    // Scan so the winning bit is the last one visited; onehot follows idx.
    always_comb begin
        found  = |vec;
        idx    = {W{1'b0}};
        onehot = {N{1'b0}};
        if (DIR == 1) begin
            for (int i = 0; i < N; i++) begin
                idx = vec[i] ? W'(i) : idx;
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                idx = vec[i] ? W'(i) : idx;
            end
        end
        if (found) begin
            onehot = ONE_N << idx;
        end else begin
            onehot = {N{1'b0}};
        end
    end

endmodule

// File: rtl/prio_encoder_hs.sv
// prio_encoder_hs: sticky multi-hot request capture with a priority-selected
// index presented on a valid/ready handshake. Served bits are cleared on
// handshake; new requests become eligible one cycle after capture.
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   req_i      in   N request pulses
//   clear_i    in   synchronous flush of pending and output state
//   out_valid  out  selection valid
//   out_ready  in   consumer accepts the selection
//   out_idx    out  W binary index of the selection
//   out_onehot out  N one-hot selection, zero when out_valid is low
//   pending_o  out  N pending register
//   dup_o      out  pulse: request arrived for an already-pending index
module prio_encoder_hs
    import prio_encoder_hs_pkg::*;
#(
    parameter  int N    = 16,
    parameter  int MODE = PRIO_LOW,
    localparam int W    = clog2_min1(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req_i,
    input  logic         clear_i,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_idx,
    output logic [N-1:0] out_onehot,
    output logic [N-1:0] pending_o,
    output logic         dup_o
);

    localparam logic [W-1:0] PTR_RST = W'(N - 1);
    localparam int MAIN_DIR = (MODE == PRIO_HIGH) ? 1 : 0;

    state_t       state_r;
    logic [W-1:0] ptr_r;

    logic         hs_s;
    logic [N-1:0] served_s;
    logic [N-1:0] cand_s;
    logic [N-1:0] mask_s;
    logic         main_found_s;
    logic [W-1:0] main_idx_s;
    logic [N-1:0] main_onehot_s;
    logic         msk_found_s;
    logic [W-1:0] msk_idx_s;
    logic [N-1:0] msk_onehot_s;
    logic         pick_found_s;
    logic [W-1:0] pick_idx_s;
    logic [N-1:0] pick_onehot_s;

    // Handshake and the vector the next selection is drawn from. In IDLE
    // served is zero, so the same expression covers both states.
    always_comb begin
        hs_s     = out_valid & out_ready;
        served_s = hs_s ? out_onehot : {N{1'b0}};
        cand_s   = pending_o & ~served_s;
    end

    // Round-robin window: only indices strictly above the last grant.
    always_comb begin
        mask_s = {N{1'b0}};
        for (int i = 0; i < N; i++) begin
            mask_s[i] = (i > int'(ptr_r));
        end
    end

    prio_pick #(.N(N), .DIR(MAIN_DIR), .W(W)) u_pick_main (
        .vec    (cand_s),
        .found  (main_found_s),
        .idx    (main_idx_s),
        .onehot (main_onehot_s)
    );

    prio_pick #(.N(N), .DIR(0), .W(W)) u_pick_masked (
        .vec    (cand_s & mask_s),
        .found  (msk_found_s),
        .idx    (msk_idx_s),
        .onehot (msk_onehot_s)
    );

    // Round-robin prefers the window above ptr, then wraps to the full scan.
    always_comb begin
        pick_found_s  = main_found_s;
        pick_idx_s    = main_idx_s;
        pick_onehot_s = main_onehot_s;
        if ((MODE == PRIO_RR) && msk_found_s) begin
            pick_found_s  = msk_found_s;
            pick_idx_s    = msk_idx_s;
            pick_onehot_s = msk_onehot_s;
        end else begin
            pick_found_s  = main_found_s;
            pick_idx_s    = main_idx_s;
            pick_onehot_s = main_onehot_s;
        end
    end

    // Pending capture, duplicate detection and the output handshake FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            ptr_r      <= PTR_RST;
            pending_o  <= {N{1'b0}};
            out_valid  <= 1'b0;
            out_idx    <= {W{1'b0}};
            out_onehot <= {N{1'b0}};
            dup_o      <= 1'b0;
        end else if (clear_i) begin
            state_r    <= ST_IDLE;
            ptr_r      <= PTR_RST;
            pending_o  <= {N{1'b0}};
            out_valid  <= 1'b0;
            out_idx    <= {W{1'b0}};
            out_onehot <= {N{1'b0}};
            dup_o      <= 1'b0;
        end else begin
            // A set and a serve of the same bit in one cycle leaves it set.
            pending_o <= cand_s | req_i;
            dup_o     <= |(req_i & cand_s);
            if (hs_s) begin
                ptr_r <= out_idx;
            end else begin
                ptr_r <= ptr_r;
            end
            case (state_r)
                ST_IDLE: begin
                    if (pick_found_s) begin
                        state_r    <= ST_HOLD;
                        out_valid  <= 1'b1;
                        out_idx    <= pick_idx_s;
                        out_onehot <= pick_onehot_s;
                    end else begin
                        state_r    <= ST_IDLE;
                        out_valid  <= 1'b0;
                        out_onehot <= {N{1'b0}};
                    end
                end
                ST_HOLD: begin
                    // Without ready the presented selection is frozen even if
                    // a higher-priority request shows up.
                    if (!out_ready) begin
                        state_r <= ST_HOLD;
                    end else if (pick_found_s) begin
                        state_r    <= ST_HOLD;
                        out_valid  <= 1'b1;
                        out_idx    <= pick_idx_s;
                        out_onehot <= pick_onehot_s;
                    end else begin
                        state_r    <= ST_IDLE;
                        out_valid  <= 1'b0;
                        out_onehot <= {N{1'b0}};
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    out_valid  <= 1'b0;
                    out_onehot <= {N{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prio_encoder_hs.sv
// Bench for prio_encoder_hs: three instances (MODE 0, 1, 2) with N = 16.
// Directed stimulus pushes hand-computed grant indices into per-instance
// queues; a monitor on the falling edge pops and compares on each handshake.
module tb_prio_encoder_hs;

    logic        clk;
    logic        rst_n;
    logic [15:0] req       [3];
    logic        clear     [3];
    logic        out_ready [3];
    logic        out_valid [3];
    logic [3:0]  out_idx   [3];
    logic [15:0] out_onehot[3];
    logic [15:0] pending_o [3];
    logic        dup_o     [3];

    int checks;
    int errors;
    int dup_cnt [3];
    int q0[$];
    int q1[$];
    int q2[$];
    int dup_base;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        prio_encoder_hs #(.N(16), .MODE(g)) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .req_i      (req[g]),
            .clear_i    (clear[g]),
            .out_valid  (out_valid[g]),
            .out_ready  (out_ready[g]),
            .out_idx    (out_idx[g]),
            .out_onehot (out_onehot[g]),
            .pending_o  (pending_o[g]),
            .dup_o      (dup_o[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Pop the expected grant for instance m and compare against the DUT.
    task automatic pop_check(input int m);
        int          exp_v;
        bit          have;
        logic [15:0] exp_oh;
        have  = 1'b0;
        exp_v = 0;
        case (m)
            0: begin have = (q0.size() > 0); if (have) exp_v = q0.pop_front(); end
            1: begin have = (q1.size() > 0); if (have) exp_v = q1.pop_front(); end
            default: begin have = (q2.size() > 0); if (have) exp_v = q2.pop_front(); end
        endcase
        checks++;
        if (!have) begin
            errors++;
            $display("FAIL unexpected_grant dut%0d got idx=%0d exp=none", m, out_idx[m]);
        end else begin
            exp_oh = 16'h0001 << exp_v;
            if (out_idx[m] !== 4'(exp_v) || out_onehot[m] !== exp_oh) begin
                errors++;
                $display("FAIL grant dut%0d got idx=%0d oh=%h exp idx=%0d oh=%h",
                         m, out_idx[m], out_onehot[m], exp_v, exp_oh);
            end
        end
    endtask

    // Monitor: grants on handshake, idle onehot, duplicate pulse counting.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int m = 0; m < 3; m++) begin
                dup_cnt[m] = dup_cnt[m] + int'(dup_o[m]);
                if (out_valid[m]) begin
                    if (out_ready[m]) pop_check(m);
                end else begin
                    checks++;
                    if (out_onehot[m] !== 16'h0000) begin
                        errors++;
                        $display("FAIL idle_onehot dut%0d got=%h exp=0000", m, out_onehot[m]);
                    end
                end
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        for (int m = 0; m < 3; m++) begin
            req[m] = 16'h0000; clear[m] = 1'b0; out_ready[m] = 1'b0; dup_cnt[m] = 0;
        end
        rst_n = 1'b0;
        #12;
        for (int m = 0; m < 3; m++) begin
            chk("rst_valid",   32'(out_valid[m]),  32'h0);
            chk("rst_idx",     32'(out_idx[m]),    32'h0);
            chk("rst_onehot",  32'(out_onehot[m]), 32'h0);
            chk("rst_pending", 32'(pending_o[m]),  32'h0);
            chk("rst_dup",     32'(dup_o[m]),      32'h0);
        end
        rst_n = 1'b1;
        tick(2);

        // 1: single-bit walk, lowest-first
        out_ready[0] = 1'b1;
        dup_base = dup_cnt[0];
        for (int k = 0; k < 16; k++) begin
            q0.push_back(k);
            req[0] = 16'h0001 << k;
            tick(1);
            req[0] = 16'h0000;
            tick(9);
        end
        chk("walk_dup", 32'(dup_cnt[0] - dup_base), 32'h0);

        // 2: multi-hot burst in lowest-first and highest-first modes
        out_ready[1] = 1'b1;
        q0.push_back(0);  q0.push_back(5);  q0.push_back(10); q0.push_back(15);
        q1.push_back(15); q1.push_back(10); q1.push_back(5);  q1.push_back(0);
        req[0] = 16'h8421;
        req[1] = 16'h8421;
        tick(1);
        req[0] = 16'h0000;
        req[1] = 16'h0000;
        tick(8);
        chk("burst_pend0",  32'(pending_o[0]), 32'h0);
        chk("burst_valid0", 32'(out_valid[0]), 32'h0);
        chk("burst_pend1",  32'(pending_o[1]), 32'h0);
        chk("burst_valid1", 32'(out_valid[1]), 32'h0);

        // 3: backpressure holds the selection despite a higher-priority arrival
        out_ready[0] = 1'b0;
        q0.push_back(3); q0.push_back(1);
        req[0] = 16'h0008;
        tick(1);
        req[0] = 16'h0000;
        tick(3);
        chk("bp_valid", 32'(out_valid[0]), 32'h1);
        chk("bp_idx",   32'(out_idx[0]),   32'h3);
        req[0] = 16'h0002;
        tick(1);
        req[0] = 16'h0000;
        tick(2);
        chk("bp_idx_held", 32'(out_idx[0]),   32'h3);
        chk("bp_pending",  32'(pending_o[0]), 32'h000A);
        out_ready[0] = 1'b1;
        tick(5);
        chk("bp_done_valid", 32'(out_valid[0]), 32'h0);
        chk("bp_done_pend",  32'(pending_o[0]), 32'h0);

        // 4: round-robin with requests held; the unserved bit re-requests
        out_ready[2] = 1'b1;
        dup_base = dup_cnt[2];
        q2.push_back(0); q2.push_back(4); q2.push_back(0);
        q2.push_back(4); q2.push_back(0); q2.push_back(4);
        req[2] = 16'h0011;
        tick(6);
        req[2] = 16'h0000;
        tick(6);
        chk("rr_dup_count", 32'(dup_cnt[2] - dup_base), 32'd5);
        chk("rr_pending",   32'(pending_o[2]), 32'h0);
        chk("rr_valid",     32'(out_valid[2]), 32'h0);

        // 5: clear during HOLD discards same-cycle request
        out_ready[0] = 1'b0;
        req[0] = 16'h0080;
        tick(1);
        req[0] = 16'h0000;
        tick(2);
        chk("clr_hold_valid", 32'(out_valid[0]), 32'h1);
        chk("clr_hold_idx",   32'(out_idx[0]),   32'h7);
        clear[0] = 1'b1;
        req[0]   = 16'h0004;
        tick(1);
        clear[0] = 1'b0;
        req[0]   = 16'h0000;
        chk("clr_valid",   32'(out_valid[0]),  32'h0);
        chk("clr_pending", 32'(pending_o[0]),  32'h0);
        chk("clr_onehot",  32'(out_onehot[0]), 32'h0);
        out_ready[0] = 1'b1;
        tick(10);
        chk("clr_no_grant", 32'(out_valid[0]), 32'h0);

        // 6: asynchronous reset mid-HOLD, then round-robin restarts at 0
        out_ready[2] = 1'b0;
        req[2] = 16'hFFFF;
        tick(1);
        req[2] = 16'h0000;
        tick(3);
        chk("prerst_valid", 32'(out_valid[2]), 32'h1);
        chk("prerst_idx",   32'(out_idx[2]),   32'h5);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_valid",   32'(out_valid[2]),  32'h0);
        chk("arst_idx",     32'(out_idx[2]),    32'h0);
        chk("arst_pending", 32'(pending_o[2]),  32'h0);
        chk("arst_onehot",  32'(out_onehot[2]), 32'h0);
        out_ready[2] = 1'b1;
        #9;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 16; k++) q2.push_back(k);
        req[2] = 16'hFFFF;
        tick(1);
        req[2] = 16'h0000;
        tick(20);
        chk("rr_all_valid",   32'(out_valid[2]), 32'h0);
        chk("rr_all_pending", 32'(pending_o[2]), 32'h0);

        chk("q0_left", 32'(q0.size()), 32'h0);
        chk("q1_left", 32'(q1.size()), 32'h0);
        chk("q2_left", 32'(q2.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prio_encoder_hs.md
Name: prio_encoder_hs

Overview:
Parametrised successor to the fixed 16-to-4 encoder. It captures multi-hot request pulses into a sticky pending register. Each cycle it picks one pending index by a selectable priority mode and presents that index on a valid/ready output handshake. It serves as the request-to-index front end for interrupt and arbitration logic; each served bit is cleared on handshake.

Parameters:
N, 16, number of request lines (N >= 2; need not be a power of 2).
MODE, 0, priority mode: 0 = fixed, lowest index wins; 1 = fixed, highest index wins; 2 = round-robin.
W, clog2(N) (min 1), index width; derived localparam, not overridable.

Ports:
clk  in  1  single clock; all state on rising edge.
rst_n  in  1  asynchronous, active-low reset.
req_i  in  N  request pulses; bit k set means index k requests service.
clear_i  in  1  synchronous flush of all pending and output state.
out_valid  out  1  out_idx/out_onehot hold a valid selection.
out_ready  in  1  consumer accepts the selection this cycle.
out_idx  out  W  binary index of the selected request.
out_onehot  out  N  one-hot form of out_idx; all zeros when out_valid=0.
pending_o  out  N  current pending register.
dup_o  out  1  one-cycle pulse: a req_i bit arrived for an already-pending index.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values, asserted immediately (no clock needed): pending=0, out_valid=0, out_idx=0, out_onehot=0, dup_o=0, RR pointer=N-1.
- Handshake: hs = out_valid & out_ready. served = out_onehot when hs, else 0.
- Pending update: pending <= (pending & ~served) | req_i. On a simultaneous set and serve of the same bit, the set wins.
- dup_o <= |(req_i & pending & ~served).
- FSM IDLE (out_valid=0): if pending != 0, select pick(pending), register idx/onehot, go to HOLD. Otherwise stay in IDLE.
- FSM HOLD (out_valid=1):
  - If !out_ready: out_idx and out_onehot are held stable, even if a higher-priority request arrives.
  - If hs and (pending & ~served) != 0: register pick(pending & ~served) and stay in HOLD. This sustains 1 grant per cycle.
  - If hs and nothing remains: go to IDLE.
- Selection never sees same-cycle req_i; new requests become eligible one cycle later.
- Latency: req_i sampled at edge k gives out_valid high after edge k+1 (2 edges from IDLE).
- Pick, MODE 0: lowest set index.
- Pick, MODE 1: highest set index.
- Pick, MODE 2: first set index scanning upward from ptr+1, wrapping N-1 to 0. ptr <= granted index on every handshake.
- clear_i has priority over everything except reset. Next cycle: pending=0, out_valid=0, out_onehot=0, ptr=N-1, dup_o=0. Same-cycle req_i is discarded.
- Reset asserted mid-HOLD drops out_valid asynchronously. No handshake is completed.
- N not a power of 2: out_idx never exceeds N-1.

Decomposition:
- Shared include defs file holds: mode constants PRIO_LOW=0, PRIO_HIGH=1, PRIO_RR=2, and the clog2 constant function.
- One natural sub-module, prio_pick: combinational (N, DIR) first-set finder with vec in, found/idx/onehot out.
- MODE 2 uses two prio_pick instances, one on the masked vector (bits above ptr) and one on the unmasked vector. The masked result is used if found.

Test Plan:
1. Single-bit walk, N=16, MODE 0, ready=1: req_i = 1<<k for k=0..15, one per 10 cycles -> out_idx=k, out_onehot=1<<k, one valid cycle each, dup_o never set.
2. MODE 0, req_i=16'h8421 for one cycle, ready=1 -> out_idx 0,5,10,15 on four consecutive cycles, then out_valid=0, pending_o=0. Same with MODE 1 -> 15,10,5,0.
3. Backpressure, MODE 0: req bit 3, ready=0 -> out_idx=3 held; inject bit 1 -> out_idx stays 3 and pending_o=16'h000A; ready=1 -> 3, then 1, then idle.
4. MODE 2, req_i held at 16'h0011, ready=1 -> out_idx alternates 0,4,0,4; dup_o pulses whenever the unserved bit is re-requested.
5. clear_i during HOLD (idx=7) with same-cycle req bit 2 -> next cycle out_valid=0, pending_o=0, no later grant of 2.
6. rst_n driven low mid-HOLD between clock edges -> out_valid, out_idx and pending_o go to 0 immediately; after release, first RR grant of req 16'hFFFF is 0.
